// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: pipeline (P) vs multicycle unit (M).
// P has fixed priority; M gets a forced grant after STARVE_MAX blocked cycles.
// Optional pending-write scoreboard is enabled by macro RF_WB_SCOREBOARD_EN.
// Ports:
//   clk, arst (async, active low)
//   p_valid/p_ready/p_rd/p_data   : pipeline writeback requester
//   m_valid/m_ready/m_rd/m_data   : multicycle writeback requester
//   rf_we/rf_waddr/rf_wdata       : registered register-file write port
//   m_issue/m_issue_rd            : multicycle op issued, target register
//   q_rs/q_rt/haz                 : hazard query against pending writes
//   pend                          : pending-write bitmap
module rf_wb_arbiter #(
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        p_valid,
   output logic        p_ready,
   input  logic [4:0]  p_rd,
   input  logic [31:0] p_data,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [4:0]  m_rd,
   input  logic [31:0] m_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   input  logic        m_issue,
   input  logic [4:0]  m_issue_rd,
   input  logic [4:0]  q_rs,
   input  logic [4:0]  q_rt,
   output logic        haz,
   output logic [31:0] pend
);

   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam logic [WW-1:0] W_MAX = WW'(STARVE_MAX);

   logic [WW-1:0] r_wcnt;
   logic          r_we;
   logic [4:0]    r_waddr;
   logic [31:0]   r_wdata;

   logic          w_force;
   logic          w_p_acc;
   logic          w_m_acc;
   logic [4:0]    w_rd;
   logic [31:0]   w_data;

   // Starved M takes the port for one cycle, P is held off.
   assign w_force = (r_wcnt == W_MAX);
   assign p_ready = !w_force;
   assign m_ready = w_force || !p_valid;

   assign w_p_acc = p_valid && p_ready;
   assign w_m_acc = m_valid && m_ready;
   assign w_rd    = w_p_acc ? p_rd : m_rd;
   assign w_data  = w_p_acc ? p_data : m_data;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_wcnt <= '0;
      end else if (!m_valid || w_m_acc) begin
         r_wcnt <= '0;
      end else if (r_wcnt != W_MAX) begin
         r_wcnt <= r_wcnt + WW'(1);
      end
   end

   // r0 is never written, but the transfer is still consumed.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_p_acc || w_m_acc) begin
         r_we    <= (w_rd != 5'd0);
         r_waddr <= w_rd;
         r_wdata <= w_data;
      end else begin
         r_we    <= 1'b0;
      end
   end

   assign rf_we    = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;

`ifdef RF_WB_SCOREBOARD_EN
   logic [31:0] r_pend;
   logic [31:0] w_set;
   logic [31:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (m_issue && m_issue_rd != 5'd0)
         w_set[m_issue_rd] = 1'b1;
      if (w_m_acc)
         w_clr[m_rd] = 1'b1;
   end

   // Set wins over clear on the same bit; bit 0 never holds.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst)
         r_pend <= '0;
      else
         r_pend <= ((r_pend & ~w_clr) | w_set) & 32'hFFFF_FFFE;
   end

   assign pend = r_pend;
   assign haz  = r_pend[q_rs] | r_pend[q_rt];
`else
   logic w_unused;
   assign w_unused = ^{m_issue, m_issue_rd, q_rs, q_rt};
   assign pend = '0;
   assign haz  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_MAX = 8).
// Inputs change just after falling edges; outputs are sampled there too.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        arst;
   logic        p_valid, p_ready;
   logic [4:0]  p_rd;
   logic [31:0] p_data;
   logic        m_valid, m_ready;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        m_issue;
   logic [4:0]  m_issue_rd;
   logic [4:0]  q_rs, q_rt;
   logic        haz;
   logic [31:0] pend;

   int n_chk  = 0;
   int n_fail = 0;

   rf_wb_arbiter #(.STARVE_MAX(8)) dut (
      .clk(clk), .arst(arst),
      .p_valid(p_valid), .p_ready(p_ready),
      .p_rd(p_rd), .p_data(p_data),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_rd(m_rd), .m_data(m_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .m_issue(m_issue), .m_issue_rd(m_issue_rd),
      .q_rs(q_rs), .q_rt(q_rt), .haz(haz), .pend(pend)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      #3;
      n_chk++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_wport: we=%b addr=%0d data=%h want 0/0/0",
                  rf_we, rf_waddr, rf_wdata);
      end
      n_chk++;
      if (pend !== 32'd0 || haz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pend: pend=%h haz=%b want 0/0", pend, haz);
      end
      @(negedge clk);
      arst = 1'b1;
      #1;
      n_chk++;
      if (p_ready !== 1'b1 || m_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: p=%b m=%b want 1/1", p_ready, m_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_p_only;
      p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hDEAD_BEEF;
      step();
      p_valid = 1'b0;
      n_chk++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL p_only: we=%b addr=%0d data=%h want 1/5/deadbeef",
                  rf_we, rf_waddr, rf_wdata);
      end
      step();
      n_chk++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL idle_hold: we=%b addr=%0d data=%h want 0/5/deadbeef",
                  rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_both;
      p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h3333_0003;
      m_valid = 1'b1; m_rd = 5'd4; m_data = 32'h4444_0004;
      #1;
      n_chk++;
      if (p_ready !== 1'b1 || m_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL both_ready1: p=%b m=%b want 1/0", p_ready, m_ready);
      end
      step();
      p_valid = 1'b0;
      n_chk++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333_0003) begin
         n_fail++;
         $display("FAIL both_p_first: we=%b addr=%0d data=%h want 1/3/33330003",
                  rf_we, rf_waddr, rf_wdata);
      end
      #1;
      n_chk++;
      if (m_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL both_ready2: m_ready=%b want 1", m_ready);
      end
      @(negedge clk);
      m_valid = 1'b0;
      n_chk++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h4444_0004) begin
         n_fail++;
         $display("FAIL both_m_second: we=%b addr=%0d data=%h want 1/4/44440004",
                  rf_we, rf_waddr, rf_wdata);
      end
      step();
   endtask

   task automatic test_starve;
      int bad = 0;
      p_valid = 1'b1; p_rd = 5'd1; p_data = 32'h0000_0011;
      m_valid = 1'b1; m_rd = 5'd9; m_data = 32'h9999_0009;
      for (int c = 1; c <= 9; c++) begin
         #1;
         if (c < 9 && (p_ready !== 1'b1 || m_ready !== 1'b0)) begin
            bad++;
            $display("FAIL starve_wait c=%0d: p=%b m=%b want 1/0",
                     c, p_ready, m_ready);
         end
         if (c == 9 && (p_ready !== 1'b0 || m_ready !== 1'b1)) begin
            bad++;
            $display("FAIL starve_force c=%0d: p=%b m=%b want 0/1",
                     c, p_ready, m_ready);
         end
         @(negedge clk);
      end
      n_chk++;
      if (bad != 0) n_fail++;
      m_valid = 1'b0;
      n_chk++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999_0009) begin
         n_fail++;
         $display("FAIL starve_mwrite: we=%b addr=%0d data=%h want 1/9/99990009",
                  rf_we, rf_waddr, rf_wdata);
      end
      #1;
      n_chk++;
      if (p_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_release: p_ready=%b want 1", p_ready);
      end
      @(negedge clk);
      p_valid = 1'b0;
      n_chk++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
         n_fail++;
         $display("FAIL starve_p_resume: we=%b addr=%0d want 1/1", rf_we, rf_waddr);
      end
      step();
   endtask

   task automatic test_rd_zero;
      p_valid = 1'b1; p_rd = 5'd0; p_data = 32'h0000_0001;
      #1;
      n_chk++;
      if (p_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rd0_ready: p_ready=%b want 1", p_ready);
      end
      @(negedge clk);
      p_valid = 1'b0;
      n_chk++;
      if (rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rd0_we: rf_we=%b want 0", rf_we);
      end
      step();
   endtask

`ifdef RF_WB_SCOREBOARD_EN
   task automatic test_scoreboard;
      m_issue = 1'b1; m_issue_rd = 5'd7;
      step();
      m_issue = 1'b0;
      q_rs = 5'd7; q_rt = 5'd0;
      #1;
      n_chk++;
      if (haz !== 1'b1 || pend !== 32'h0000_0080) begin
         n_fail++;
         $display("FAIL sb_set: haz=%b pend=%h want 1/00000080", haz, pend);
      end
      q_rs = 5'd2; q_rt = 5'd3;
      #1;
      n_chk++;
      if (haz !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_nohaz: haz=%b want 0", haz);
      end
      @(negedge clk);
      m_valid = 1'b1; m_rd = 5'd7; m_data = 32'h7777_0007;
      m_issue = 1'b1; m_issue_rd = 5'd7;
      step();
      m_valid = 1'b0; m_issue = 1'b0;
      q_rs = 5'd0; q_rt = 5'd7;
      #1;
      n_chk++;
      if (pend !== 32'h0000_0080 || haz !== 1'b1 || rf_waddr !== 5'd7) begin
         n_fail++;
         $display("FAIL sb_setwins: pend=%h haz=%b addr=%0d want 00000080/1/7",
                  pend, haz, rf_waddr);
      end
      @(negedge clk);
      m_valid = 1'b1;
      m_issue = 1'b1; m_issue_rd = 5'd0;
      step();
      m_valid = 1'b0; m_issue = 1'b0;
      n_chk++;
      if (pend !== 32'd0) begin
         n_fail++;
         $display("FAIL sb_clear: pend=%h want 0", pend);
      end
   endtask
`else
   task automatic test_no_scoreboard;
      m_issue = 1'b1; m_issue_rd = 5'd7;
      q_rs = 5'd7; q_rt = 5'd7;
      step();
      m_issue = 1'b0;
      n_chk++;
      if (haz !== 1'b0 || pend !== 32'd0) begin
         n_fail++;
         $display("FAIL nosb_tied: haz=%b pend=%h want 0/0", haz, pend);
      end
   endtask
`endif

   task automatic test_reset_mid;
      p_valid = 1'b1; p_rd = 5'd2; p_data = 32'h2222_0002;
      m_valid = 1'b1; m_rd = 5'd6; m_data = 32'h6666_0006;
      m_issue = 1'b1; m_issue_rd = 5'd12;
      step();
      m_issue = 1'b0;
      repeat (4) step();
      n_chk++;
      if (dut.r_wcnt !== 4'd5 || rf_we !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre: wcnt=%0d we=%b want 5/1", dut.r_wcnt, rf_we);
      end
      #2;
      arst = 1'b0;
      #1;
      n_chk++;
      if (rf_we !== 1'b0 || dut.r_wcnt !== 4'd0 || pend !== 32'd0 ||
          rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_async: we=%b wcnt=%0d pend=%h addr=%0d data=%h want zeros",
                  rf_we, dut.r_wcnt, pend, rf_waddr, rf_wdata);
      end
      p_valid = 1'b0; m_valid = 1'b0;
      @(negedge clk);
      step();
      arst = 1'b1;
      step();
      n_chk++;
      if (rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_nowrite: rf_we=%b want 0", rf_we);
      end
      m_valid = 1'b1;
      #1;
      n_chk++;
      if (p_ready !== 1'b1 || m_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready: p=%b m=%b want 1/1", p_ready, m_ready);
      end
      m_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      arst = 1'b0;
      p_valid = 1'b0; p_rd = '0; p_data = '0;
      m_valid = 1'b0; m_rd = '0; m_data = '0;
      m_issue = 1'b0; m_issue_rd = '0;
      q_rs = '0; q_rt = '0;
      test_reset();
      test_p_only();
      test_both();
      test_starve();
      test_rd_zero();
`ifdef RF_WB_SCOREBOARD_EN
      test_scoreboard();
`else
      test_no_scoreboard();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
